// File: rtl/alu_sequencer_pkg.sv
// Shared types and field positions for the Hack-style ALU sequencer.
package alu_sequencer_pkg;

  localparam int unsigned DATA_WIDTH  = 8;
  localparam int unsigned INSTR_WIDTH = 16;

  // Instruction field bit positions
  localparam int unsigned IS_C    = 15;
  localparam int unsigned A_BIT   = 12;
  localparam int unsigned COMP_HI = 11;
  localparam int unsigned COMP_LO = 6;
  localparam int unsigned DEST_HI = 5;
  localparam int unsigned DEST_LO = 3;
  localparam int unsigned JUMP_HI = 2;
  localparam int unsigned JUMP_LO = 0;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_READ  = 2'd1,
    ST_EXEC  = 2'd2,
    ST_WRITE = 2'd3
  } state_e;

  typedef struct packed {
    logic zx;
    logic nx;
    logic zy;
    logic ny;
    logic f;
    logic no;
  } alu_ctrl_t;

  // Low 13 bits of a C-instruction: everything the sequencer keeps in ir
  typedef struct packed {
    logic      a;
    alu_ctrl_t comp;
    logic      dest_a;
    logic      dest_d;
    logic      dest_m;
    logic [2:0] jump;  // {lt, eq, gt}
  } ctrl_t;

endpackage

// File: rtl/alu_sequencer_if.sv
// Instruction-fetch and data-memory handshake bus.
interface alu_sequencer_if;
  import alu_sequencer_pkg::*;

  logic                   instr_req;
  logic [DATA_WIDTH-1:0]  instr_addr;
  logic                   instr_valid;
  logic [INSTR_WIDTH-1:0] instr_data;

  logic [DATA_WIDTH-1:0]  mem_addr;
  logic                   mem_rd;
  logic                   mem_rvalid;
  logic [DATA_WIDTH-1:0]  mem_rdata;
  logic                   mem_we;
  logic                   mem_wready;
  logic [DATA_WIDTH-1:0]  mem_wdata;

  modport master (
    output instr_req, instr_addr, mem_addr, mem_rd, mem_we, mem_wdata,
    input  instr_valid, instr_data, mem_rvalid, mem_rdata, mem_wready
  );

  modport slave (
    input  instr_req, instr_addr, mem_addr, mem_rd, mem_we, mem_wdata,
    output instr_valid, instr_data, mem_rvalid, mem_rdata, mem_wready
  );

endinterface

// File: rtl/alu_sequencer_jump_unit.sv
// Result flags and jump decision for a C-instruction.
module jump_unit
  import alu_sequencer_pkg::*;
(
  input  logic [DATA_WIDTH-1:0] result,
  input  logic [2:0]            jump,
  output logic                  zr,
  output logic                  ng,
  output logic                  take
);

  // Flags from the ALU result, then the lt/eq/gt select
  always_comb begin
    zr   = (result == '0);
    ng   = result[DATA_WIDTH-1];
    take = (jump[2] & ng) | (jump[1] & zr) | (jump[0] & ~ng & ~zr);
  end

endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle Hack-style control unit driving an external 8-bit ALU.
module alu_sequencer
  import alu_sequencer_pkg::*;
#(
  parameter logic [DATA_WIDTH-1:0] PC_RESET = 8'h00
) (
  input  logic                  clk,
  input  logic                  rst,
  alu_sequencer_if.master       bus,
  output logic                  alu_zx,
  output logic                  alu_nx,
  output logic                  alu_zy,
  output logic                  alu_ny,
  output logic                  alu_f,
  output logic                  alu_no,
  output logic [DATA_WIDTH-1:0] alu_x,
  output logic [DATA_WIDTH-1:0] alu_y,
  input  logic [DATA_WIDTH-1:0] alu_o,
  output logic                  retire,
  output logic [DATA_WIDTH-1:0] pc_o,
  output logic [DATA_WIDTH-1:0] a_o,
  output logic [DATA_WIDTH-1:0] d_o
);

  state_e                state;
  ctrl_t                 ir;
  logic [DATA_WIDTH-1:0] pc;
  logic [DATA_WIDTH-1:0] a_reg;
  logic [DATA_WIDTH-1:0] d_reg;
  logic [DATA_WIDTH-1:0] mdr;
  logic [DATA_WIDTH-1:0] y_reg;
  logic                  instr_req;
  logic                  mem_rd;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;

  logic                  zr;
  logic                  ng;
  logic                  take;
  ctrl_t                 fetched;
  logic                  unused_bits;

  assign fetched = ctrl_t'(bus.instr_data[A_BIT:0]);

  // Reserved opcode bits and the raw flags have no consumer in this block
  assign unused_bits = ^{bus.instr_data[IS_C-1:A_BIT+1], zr, ng};

  jump_unit u_jump (
    .result (alu_o),
    .jump   (ir.jump),
    .zr     (zr),
    .ng     (ng),
    .take   (take)
  );

  // Outputs are straight register taps
  assign {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no} = ir.comp;
  assign alu_x          = d_reg;
  assign alu_y          = y_reg;
  assign pc_o           = pc;
  assign a_o            = a_reg;
  assign d_o            = d_reg;
  assign bus.instr_req  = instr_req;
  assign bus.instr_addr = pc;
  assign bus.mem_rd     = mem_rd;
  assign bus.mem_we     = mem_we;
  assign bus.mem_addr   = mem_addr;
  assign bus.mem_wdata  = mem_wdata;

  // Sequencer FSM; y_reg tracks (ir.a ? mdr : A) so alu_y stays a flop output
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_FETCH;
      ir        <= '0;
      pc        <= PC_RESET;
      a_reg     <= '0;
      d_reg     <= '0;
      mdr       <= '0;
      y_reg     <= '0;
      instr_req <= 1'b1;
      mem_rd    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      retire    <= 1'b0;
    end else begin
      retire <= 1'b0;
      case (state)
        ST_FETCH: begin
          if (bus.instr_valid) begin
            ir <= fetched;
            if (!bus.instr_data[IS_C]) begin
              a_reg  <= bus.instr_data[DATA_WIDTH-1:0];
              y_reg  <= fetched.a ? mdr : bus.instr_data[DATA_WIDTH-1:0];
              pc     <= pc + DATA_WIDTH'(1);
              retire <= 1'b1;
            end else if (fetched.a) begin
              instr_req <= 1'b0;
              mem_rd    <= 1'b1;
              mem_addr  <= a_reg;
              y_reg     <= mdr;
              state     <= ST_READ;
            end else begin
              instr_req <= 1'b0;
              y_reg     <= a_reg;
              state     <= ST_EXEC;
            end
          end
        end
        ST_READ: begin
          if (bus.mem_rvalid) begin
            mdr    <= bus.mem_rdata;
            y_reg  <= bus.mem_rdata;
            mem_rd <= 1'b0;
            state  <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (ir.dest_d) d_reg <= alu_o;
          if (ir.dest_a) a_reg <= alu_o;
          y_reg <= ir.a ? mdr : (ir.dest_a ? alu_o : a_reg);
          // Jump target is A as it was before this instruction's write
          pc    <= take ? a_reg : pc + DATA_WIDTH'(1);
          if (ir.dest_m) begin
            mem_we    <= 1'b1;
            mem_addr  <= a_reg;
            mem_wdata <= alu_o;
            state     <= ST_WRITE;
          end else begin
            retire    <= 1'b1;
            instr_req <= 1'b1;
            state     <= ST_FETCH;
          end
        end
        ST_WRITE: begin
          if (bus.mem_wready) begin
            mem_we    <= 1'b0;
            retire    <= 1'b1;
            instr_req <= 1'b1;
            state     <= ST_FETCH;
          end
        end
        default: state <= ST_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench: reference model predicts state per instruction, memory
// responders with programmable latency, external ALU modelled here.
module tb_alu_sequencer;
  import alu_sequencer_pkg::*;

  typedef struct {
    logic [7:0] pc;
    logic [7:0] a;
    logic [7:0] d;
  } arch_t;

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic rst;
  logic alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no;
  logic [7:0] alu_x, alu_y, alu_o;
  logic retire;
  logic [7:0] pc_o, a_o, d_o;

  alu_sequencer_if bus ();

  alu_sequencer #(.PC_RESET(8'h00)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus),
    .alu_zx (alu_zx),
    .alu_nx (alu_nx),
    .alu_zy (alu_zy),
    .alu_ny (alu_ny),
    .alu_f  (alu_f),
    .alu_no (alu_no),
    .alu_x  (alu_x),
    .alu_y  (alu_y),
    .alu_o  (alu_o),
    .retire (retire),
    .pc_o   (pc_o),
    .a_o    (a_o),
    .d_o    (d_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int n_issued = 0;
  int n_retired = 0;
  int n_aborted = 0;
  int rd_delay = 0;
  int wr_delay = 0;
  int rd_seen = 0;
  int we_seen = 0;
  int last_rd_cycles = 0;
  int last_we_cycles = 0;
  logic [7:0] rd_addr0, we_addr0, we_data0;

  logic [7:0] dmem  [256];
  logic [7:0] m_mem [256];
  logic [7:0] m_pc, m_a, m_d;
  arch_t exp_q [$];
  wr_t   wq [$];
  logic [7:0] rq [$];
  arch_t mon_e;
  wr_t   wr_e;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] alu_ref(input logic [5:0] c, input logic [7:0] x,
                                         input logic [7:0] y);
    logic [7:0] xx, yy, r;
    xx = c[5] ? 8'h00 : x;
    if (c[4]) xx = ~xx;
    yy = c[3] ? 8'h00 : y;
    if (c[2]) yy = ~yy;
    r = c[1] ? 8'(xx + yy) : (xx & yy);
    if (c[0]) r = ~r;
    return r;
  endfunction

  // External combinational ALU
  always_comb alu_o = alu_ref({alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no}, alu_x, alu_y);

  task automatic model_reset();
    m_pc = 8'h00;
    m_a  = 8'h00;
    m_d  = 8'h00;
  endtask

  task automatic model_step(input logic [15:0] ins);
    logic [7:0] y, o, old_a;
    logic [5:0] comp;
    logic zr, ng, tk;
    arch_t e;
    wr_t w;
    if (!ins[15]) begin
      m_a  = ins[7:0];
      m_pc = m_pc + 8'd1;
    end else begin
      if (ins[12]) rq.push_back(m_a);
      y     = ins[12] ? m_mem[m_a] : m_a;
      comp  = ins[11:6];
      o     = alu_ref(comp, m_d, y);
      old_a = m_a;
      zr    = (o == 8'h00);
      ng    = o[7];
      tk    = (ins[2] & ng) | (ins[1] & zr) | (ins[0] & ~ng & ~zr);
      if (ins[4]) m_d = o;
      if (ins[5]) m_a = o;
      m_pc = tk ? old_a : m_pc + 8'd1;
      if (ins[3]) begin
        m_mem[old_a] = o;
        w.addr = old_a;
        w.data = o;
        wq.push_back(w);
      end
    end
    e.pc = m_pc;
    e.a  = m_a;
    e.d  = m_d;
    exp_q.push_back(e);
  endtask

  // Wait for a fetch request, predict, present the word for one cycle
  task automatic issue(input logic [15:0] ins, input int rdly, input int wdly);
    int n = 0;
    while (!bus.instr_req && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("fetch_req", 32'(bus.instr_req), 32'd1);
    chk("fetch_addr", 32'(bus.instr_addr), 32'(m_pc));
    rd_delay = rdly;
    wr_delay = wdly;
    model_step(ins);
    n_issued++;
    bus.instr_data  = ins;
    bus.instr_valid = 1'b1;
    @(negedge clk);
    bus.instr_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_q.size() != 0 || !bus.instr_req) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) chk("idle_timeout", 32'(n), 32'd0);
  endtask

  // Retire scoreboard
  always @(negedge clk) begin
    if (!rst && retire) begin
      n_retired++;
      if (exp_q.size() == 0) chk("retire_unexp", 32'(exp_q.size()), 32'd1);
      else begin
        mon_e = exp_q.pop_front();
        chk("ret_pc", 32'(pc_o), 32'(mon_e.pc));
        chk("ret_a", 32'(a_o), 32'(mon_e.a));
        chk("ret_d", 32'(d_o), 32'(mon_e.d));
      end
    end
  end

  // Data-memory read responder
  initial begin
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = 8'h00;
    forever begin
      @(negedge clk);
      bus.mem_rvalid = 1'b0;
      if (bus.mem_rd && !rst) begin
        if (rd_seen == 0) rd_addr0 = bus.mem_addr;
        else chk("rd_addr_hold", 32'(bus.mem_addr), 32'(rd_addr0));
        rd_seen++;
        if (rd_seen > rd_delay) begin
          bus.mem_rvalid = 1'b1;
          bus.mem_rdata  = dmem[bus.mem_addr];
          last_rd_cycles = rd_seen;
          rd_seen = 0;
          if (rq.size() == 0) chk("rd_unexp", 32'(rq.size()), 32'd1);
          else chk("rd_addr", 32'(bus.mem_addr), 32'(rq.pop_front()));
        end
      end else begin
        rd_seen = 0;
      end
    end
  end

  // Data-memory write responder
  initial begin
    bus.mem_wready = 1'b0;
    forever begin
      @(negedge clk);
      bus.mem_wready = 1'b0;
      if (bus.mem_we && !rst) begin
        if (we_seen == 0) begin
          we_addr0 = bus.mem_addr;
          we_data0 = bus.mem_wdata;
        end else begin
          chk("wr_addr_hold", 32'(bus.mem_addr), 32'(we_addr0));
          chk("wr_data_hold", 32'(bus.mem_wdata), 32'(we_data0));
        end
        we_seen++;
        if (we_seen > wr_delay) begin
          bus.mem_wready = 1'b1;
          dmem[bus.mem_addr] = bus.mem_wdata;
          last_we_cycles = we_seen;
          we_seen = 0;
          if (wq.size() == 0) chk("wr_unexp", 32'(wq.size()), 32'd1);
          else begin
            wr_e = wq.pop_front();
            chk("wr_addr", 32'(bus.mem_addr), 32'(wr_e.addr));
            chk("wr_data", 32'(bus.mem_wdata), 32'(wr_e.data));
          end
        end
      end else begin
        we_seen = 0;
      end
    end
  end

  initial begin
    logic [15:0] ins;
    rst = 1'b1;
    bus.instr_valid = 1'b0;
    bus.instr_data  = 16'h0000;
    for (int i = 0; i < 256; i++) begin
      dmem[i]  = 8'(i * 3 + 1);
      m_mem[i] = dmem[i];
    end
    dmem[5]  = 8'h03;
    m_mem[5] = 8'h03;
    model_reset();

    // Reset held for two edges
    repeat (2) @(negedge clk);
    chk("rst_pc", 32'(pc_o), 32'h0);
    chk("rst_a", 32'(a_o), 32'h0);
    chk("rst_d", 32'(d_o), 32'h0);
    chk("rst_req", 32'(bus.instr_req), 32'd1);
    chk("rst_iaddr", 32'(bus.instr_addr), 32'h0);
    chk("rst_retire", 32'(retire), 32'd0);
    chk("rst_rd", 32'(bus.mem_rd), 32'd0);
    chk("rst_we", 32'(bus.mem_we), 32'd0);
    rst = 1'b0;

    // @5 ; D=A ; D=D+M with slow read ; M=D-1 with slow write
    issue(16'h0005, 0, 0);
    wait_idle();
    chk("ainst_a", 32'(a_o), 32'h05);
    chk("ainst_pc", 32'(pc_o), 32'h01);
    issue(16'hEC10, 0, 0);
    chk("ec10_ctrl", 32'({alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no}), 32'b110000);
    chk("ec10_y", 32'(alu_y), 32'h05);
    wait_idle();
    chk("ec10_d", 32'(d_o), 32'h05);
    chk("ec10_pc", 32'(pc_o), 32'h02);
    issue(16'hF090, 3, 0);
    wait_idle();
    chk("rd_cycles", 32'(last_rd_cycles), 32'd4);
    chk("dpm_d", 32'(d_o), 32'h08);
    issue(16'hE388, 0, 2);
    wait_idle();
    chk("wr_cycles", 32'(last_we_cycles), 32'd3);
    chk("wr_mem5", 32'(dmem[5]), 32'h07);

    // Jumps: taken JGT, not-taken JGT on zero, JEQ on zero, JMP, pc wrap
    issue(16'h0007, 0, 0);
    issue(16'hEC10, 0, 0);
    issue(16'h0005, 0, 0);
    issue(16'hE301, 0, 0);
    wait_idle();
    chk("jgt_taken", 32'(pc_o), 32'h05);
    issue(16'hEA90, 0, 0);
    issue(16'hE301, 0, 0);
    wait_idle();
    chk("jgt_zero", 32'(pc_o), 32'h07);
    issue(16'hE302, 0, 0);
    wait_idle();
    chk("jeq_zero", 32'(pc_o), 32'h05);
    issue(16'h00FF, 0, 0);
    issue(16'hEA87, 0, 0);
    wait_idle();
    chk("jmp_ff", 32'(pc_o), 32'hFF);
    issue(16'h0003, 0, 0);
    wait_idle();
    chk("pc_wrap", 32'(pc_o), 32'h00);

    // Random mix, all checked through the scoreboard
    for (int k = 0; k < 60; k++) begin
      if ($urandom_range(0, 2) == 0) ins = {1'b0, 15'($urandom)};
      else ins = {3'b111, 13'($urandom)};
      issue(ins, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end
    wait_idle();

    // Reset while a read is outstanding
    issue(16'hF090, 1000, 0);
    repeat (2) @(negedge clk);
    chk("rd_pending", 32'(bus.mem_rd), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_rd", 32'(bus.mem_rd), 32'd0);
    chk("abort_req", 32'(bus.instr_req), 32'd1);
    chk("abort_pc", 32'(pc_o), 32'h00);
    chk("abort_a", 32'(a_o), 32'h00);
    chk("abort_d", 32'(d_o), 32'h00);
    chk("abort_retire", 32'(retire), 32'd0);
    rst = 1'b0;
    exp_q.delete();
    rq.delete();
    model_reset();
    n_aborted++;
    issue(16'h0009, 0, 0);
    issue(16'hF090, 1, 0);
    wait_idle();
    chk("post_rst_d", 32'(d_o), 32'(m_d));
    chk("post_rst_pc", 32'(pc_o), 32'h02);

    repeat (3) @(negedge clk);
    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    chk("rq_empty", 32'(rq.size()), 32'd0);
    chk("wq_empty", 32'(wq.size()), 32'd0);
    chk("retire_count", 32'(n_retired), 32'(n_issued - n_aborted));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
